// File: rtl/ast_width_upsizer.sv
// Avalon-ST width upsizer: packs RATIO narrow beats into one wide beat and recomputes empty.
// Optional macro AST_UPSIZER_PKT_CHECK_EN adds pkt_err_o protocol-violation reporting.
module ast_width_upsizer #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 256,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W/8)  > 0) ? $clog2(DATA_IN_W/8)  : 1,
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W/8) > 0) ? $clog2(DATA_OUT_W/8) : 1
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
`ifdef AST_UPSIZER_PKT_CHECK_EN
  ,
  output logic                   pkt_err_o
`endif
);

  localparam int RATIO    = DATA_OUT_W / DATA_IN_W;
  localparam int IN_BYTES = DATA_IN_W / 8;
  localparam int IDX_W    = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(RATIO - 1);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_OUT_W-1:0]   acc_q;
  logic                    acc_sop_q;
  logic [CHANNEL_W-1:0]    acc_channel_q;

  logic                    accept, start, restart, flush, take, commit, load;
  logic [IDX_W-1:0]        lane, lim;
  logic [DATA_OUT_W-1:0]   word_d;
  logic                    sop_d, eop_d;
  logic [EMPTY_OUT_W-1:0]  empty_d;
  logic [CHANNEL_W-1:0]    channel_d;

`ifdef AST_UPSIZER_PKT_CHECK_EN
  logic stray;
  logic err_q;
  assign pkt_err_o = err_q;
`endif

  assign ast_ready_o = !ast_valid_o || ast_ready_i;
  assign accept      = ast_valid_i && ast_ready_o;

  always_ff @(posedge clk) begin
    if (srst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (take) state_d = ast_endofpacket_i ? IDLE : IN_PKT;
  end

  // Beat decode and assembly of the word that would be loaded into the output register.
  always_comb begin
    start   = accept && (state_q == IDLE) && ast_startofpacket_i;
    restart = 1'b0;
`ifdef AST_UPSIZER_PKT_CHECK_EN
    restart = accept && (state_q == IN_PKT) && ast_startofpacket_i;
    stray   = accept && (state_q == IDLE) && !ast_startofpacket_i;
`endif
    flush  = restart && (idx_q != '0);
    take   = start || (accept && (state_q == IN_PKT));
    lane   = (start || restart) ? '0 : idx_q;
    commit = take && ((lane == LAST_LANE) || ast_endofpacket_i);
    load   = flush || commit;
    lim    = flush ? idx_q : lane;

    word_d = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (IDX_W'(j) < lim)
        word_d[DATA_OUT_W-1-j*DATA_IN_W -: DATA_IN_W] = acc_q[DATA_OUT_W-1-j*DATA_IN_W -: DATA_IN_W];
      else if ((IDX_W'(j) == lim) && !flush)
        word_d[DATA_OUT_W-1-j*DATA_IN_W -: DATA_IN_W] = ast_data_i;
    end

    // A flushed partial word behaves as if its last beat ended with empty 0.
    if (flush) begin
      sop_d     = acc_sop_q;
      channel_d = acc_channel_q;
      eop_d     = 1'b1;
      empty_d   = EMPTY_OUT_W'((RATIO - int'(idx_q)) * IN_BYTES);
    end else begin
      sop_d     = (lane == '0) ? (start || restart) : acc_sop_q;
      channel_d = (lane == '0) ? ast_channel_i : acc_channel_q;
      eop_d     = ast_endofpacket_i;
      empty_d   = ast_endofpacket_i
                ? EMPTY_OUT_W'((RATIO - 1 - int'(lane)) * IN_BYTES + int'(ast_empty_i))
                : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      idx_q               <= '0;
      acc_q               <= '0;
      acc_sop_q           <= 1'b0;
      acc_channel_q       <= '0;
      ast_valid_o         <= 1'b0;
      ast_data_o          <= '0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else begin
      if (take) begin
        acc_q[DATA_OUT_W-1-int'(lane)*DATA_IN_W -: DATA_IN_W] <= ast_data_i;
        if (lane == '0) begin
          acc_sop_q     <= start || restart;
          acc_channel_q <= ast_channel_i;
        end
        idx_q <= commit ? '0 : lane + 1'b1;
      end
      if (load) begin
        ast_valid_o         <= 1'b1;
        ast_data_o          <= word_d;
        ast_startofpacket_o <= sop_d;
        ast_endofpacket_o   <= eop_d;
        ast_empty_o         <= empty_d;
        ast_channel_o       <= channel_d;
      end else if (ast_ready_i) begin
        ast_valid_o <= 1'b0;
      end
    end
  end

`ifdef AST_UPSIZER_PKT_CHECK_EN
  always_ff @(posedge clk) begin
    if (srst) err_q <= 1'b0;
    else      err_q <= stray || restart;
  end
`endif

endmodule

// File: tb/tb_ast_width_upsizer.sv
// Self-checking bench for ast_width_upsizer: packet table, corner sequences and random traffic
// scored against a queue-based packing model.
module tb_ast_width_upsizer;

  localparam int DIN = 64;
  localparam int DOUT = 256;
  localparam int RATIO = DOUT / DIN;

  logic        clk = 1'b0;
  logic        srst;
  logic [63:0] ast_data_i;
  logic        ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
  logic [2:0]  ast_empty_i;
  logic [9:0]  ast_channel_i;
  logic        ast_ready_o;
  logic [255:0] ast_data_o;
  logic        ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
  logic [4:0]  ast_empty_o;
  logic [9:0]  ast_channel_o;
  logic        ast_ready_i;
`ifdef AST_UPSIZER_PKT_CHECK_EN
  logic        pkt_err_o;
`endif

  ast_width_upsizer dut (
    .clk(clk), .srst(srst),
    .ast_data_i(ast_data_i), .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i(ast_endofpacket_i), .ast_valid_i(ast_valid_i),
    .ast_empty_i(ast_empty_i), .ast_channel_i(ast_channel_i), .ast_ready_o(ast_ready_o),
    .ast_data_o(ast_data_o), .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o(ast_endofpacket_o), .ast_valid_o(ast_valid_o),
    .ast_empty_o(ast_empty_o), .ast_channel_o(ast_channel_o), .ast_ready_i(ast_ready_i)
`ifdef AST_UPSIZER_PKT_CHECK_EN
    , .pkt_err_o(pkt_err_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
    logic [9:0]   ch;
  } word_t;

  typedef struct {
    int nbeats;
    int last_empty;
    int channel;
    int exp_words;
    int exp_last_empty;
  } vec_t;

  int tests_run = 0;
  int tests_failed = 0;

  word_t       exp_q[$];
  logic [63:0] cur_beats[$];
  logic [9:0]  cur_ch;
  logic        in_pkt_m = 1'b0;
  logic        first_word;
  logic        beat_accepted;
  logic        held = 1'b0;
  word_t       held_word;
  int          pkt_words;
  int          last_empty_seen;
  int          bp_cycles = 0;
  logic        rand_ready = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: collect beats of the open packet, emit a word every RATIO beats or at EOP.
  task automatic model_beat();
    word_t w;
    if (!in_pkt_m) begin
      if (!ast_startofpacket_i) return;
      in_pkt_m   = 1'b1;
      first_word = 1'b1;
      cur_beats.delete();
    end
    if (cur_beats.size() == 0) cur_ch = ast_channel_i;
    cur_beats.push_back(ast_data_i);
    if (cur_beats.size() == RATIO || ast_endofpacket_i) begin
      w.data = '0;
      foreach (cur_beats[i]) w.data = (w.data << DIN) | 256'(cur_beats[i]);
      w.data  = w.data << (DIN * (RATIO - cur_beats.size()));
      w.sop   = first_word;
      w.eop   = ast_endofpacket_i;
      w.empty = ast_endofpacket_i ? 5'(RATIO*8 - (cur_beats.size()*8 - int'(ast_empty_i))) : 5'd0;
      w.ch    = cur_ch;
      exp_q.push_back(w);
      first_word = 1'b0;
      cur_beats.delete();
      if (ast_endofpacket_i) in_pkt_m = 1'b0;
    end
  endtask

  task automatic check_output();
    word_t w;
    if (exp_q.size() == 0) begin
      check("unexpected word", 256'(ast_data_o), 256'(0));
      return;
    end
    w = exp_q.pop_front();
    check("word data", ast_data_o, w.data);
    check("word sop", 256'(ast_startofpacket_o), 256'(w.sop));
    check("word eop", 256'(ast_endofpacket_o), 256'(w.eop));
    check("word empty", 256'(ast_empty_o), 256'(w.empty));
    check("word channel", 256'(ast_channel_o), 256'(w.ch));
    pkt_words++;
    if (ast_endofpacket_o) last_empty_seen = int'(ast_empty_o);
  endtask

  // One clock: choose sink-side ready, sample at negedge, score, return #1 after posedge.
  task automatic step();
    if (bp_cycles > 0 && ast_valid_o) begin
      ast_ready_i = 1'b0;
      bp_cycles--;
    end else if (rand_ready) ast_ready_i = ($urandom_range(3) != 0);
    else ast_ready_i = 1'b1;
    @(negedge clk);
    beat_accepted = ast_valid_i && ast_ready_o;
    if (srst) begin
      exp_q.delete();
      cur_beats.delete();
      in_pkt_m = 1'b0;
      held = 1'b0;
    end else begin
      if (held) begin
        check("held data stable", ast_data_o, held_word.data);
        check("held empty stable", 256'(ast_empty_o), 256'(held_word.empty));
      end
      if (ast_valid_o && ast_ready_i) check_output();
      held = ast_valid_o && !ast_ready_i;
      held_word.data  = ast_data_o;
      held_word.empty = ast_empty_o;
      if (held) check("ready_o low while held", 256'(ast_ready_o), 256'(0));
      if (beat_accepted) model_beat();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [63:0] d, input logic sop, input logic eop,
                                input logic [2:0] e, input logic [9:0] ch);
    ast_data_i = d; ast_startofpacket_i = sop; ast_endofpacket_i = eop;
    ast_empty_i = e; ast_channel_i = ch; ast_valid_i = 1'b1;
    beat_accepted = 1'b0;
    for (int t = 0; t < 100 && !beat_accepted; t++) step();
    if (!beat_accepted) check("beat accept timeout", 256'(0), 256'(1));
    ast_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int last_empty, input int ch);
    for (int i = 0; i < n; i++)
      apply_stimulus({$urandom, $urandom}, i == 0, i == n - 1,
                     (i == n - 1) ? 3'(last_empty) : 3'($urandom_range(7)), 10'(ch));
  endtask

  task automatic check_output_drained();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || ast_valid_o); t++) step();
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4, 0, 5, 1, 0};
    vecs[1] = '{6, 3, 5, 2, 19};
    vecs[2] = '{1, 5, 7, 1, 29};
    vecs[3] = '{8, 0, 3, 2, 0};
    vecs[4] = '{3, 7, 1, 1, 15};
    vecs[5] = '{5, 1, 2, 2, 25};

    srst = 1'b1; ast_valid_i = 1'b0; ast_data_i = '0; ast_startofpacket_i = 1'b0;
    ast_endofpacket_i = 1'b0; ast_empty_i = '0; ast_channel_i = '0; ast_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    srst = 1'b0;
    check("reset valid", 256'(ast_valid_o), 256'(0));
    check("reset data", ast_data_o, 256'(0));
    check("reset sop/eop", 256'({ast_startofpacket_o, ast_endofpacket_o}), 256'(0));
    check("reset empty/channel", 256'({ast_empty_o, ast_channel_o}), 256'(0));
    check("reset ready_o", 256'(ast_ready_o), 256'(1));

    for (int v = 0; v < 6; v++) begin
      pkt_words = 0; last_empty_seen = -1;
      send_pkt(vecs[v].nbeats, vecs[v].last_empty, vecs[v].channel);
      check_output_drained();
      check("table word count", 256'(pkt_words), 256'(vecs[v].exp_words));
      check("table last empty", 256'(last_empty_seen), 256'(vecs[v].exp_last_empty));
    end

    // Full word: output must be valid the cycle after the committing beat.
    apply_stimulus(64'hD0, 1'b1, 1'b0, 3'd0, 10'd5);
    apply_stimulus(64'hD1, 1'b0, 1'b0, 3'd0, 10'd5);
    apply_stimulus(64'hD2, 1'b0, 1'b0, 3'd0, 10'd5);
    check("no word before commit", 256'(ast_valid_o), 256'(0));
    apply_stimulus(64'hD3, 1'b0, 1'b1, 3'd0, 10'd5);
    check("latency valid", 256'(ast_valid_o), 256'(1));
    check("latency data", ast_data_o, {64'hD0, 64'hD1, 64'hD2, 64'hD3});
    check("latency sop/eop/ch", 256'({ast_startofpacket_o, ast_endofpacket_o, ast_channel_o}),
          256'({1'b1, 1'b1, 10'd5}));
    check_output_drained();

    // Backpressure: sink stalls 10 cycles after the first word of a 12-beat packet.
    pkt_words = 0;
    bp_cycles = 10;
    send_pkt(12, 0, 9);
    check_output_drained();
    check("backpressure word count", 256'(pkt_words), 256'(3));
    check("backpressure cycles consumed", 256'(bp_cycles), 256'(0));

    // Stray beat outside a packet is discarded.
    apply_stimulus(64'hBAD, 1'b0, 1'b1, 3'd0, 10'd1);
    step();
    check("stray beat no output", 256'(ast_valid_o), 256'(0));

    // Reset in the middle of a packet, then a fresh packet.
    apply_stimulus(64'hA0, 1'b1, 1'b0, 3'd0, 10'd4);
    apply_stimulus(64'hA1, 1'b0, 1'b0, 3'd0, 10'd4);
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("post-reset ready_o", 256'(ast_ready_o), 256'(1));
    check("post-reset valid", 256'(ast_valid_o), 256'(0));
    pkt_words = 0;
    send_pkt(4, 0, 6);
    check_output_drained();
    check("post-reset word count", 256'(pkt_words), 256'(1));

    // Random traffic with random sink ready, stray beats and mid-packet SOPs.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(4) == 0) step();
      else apply_stimulus({$urandom, $urandom}, $urandom_range(3) == 0, $urandom_range(3) == 0,
                          3'($urandom_range(7)), 10'($urandom_range(1023)));
    end
    apply_stimulus(64'h1, 1'b0, 1'b1, 3'd0, 10'd0);
    rand_ready = 1'b0;
    check_output_drained();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
